oclib_cdc_bus_sender: RTL and testbench

Source-side half of a toggle-handshake bus clock-domain crossing. Accepts words on a valid/ready interface and holds each word stable on `cdc_data` while it flips `cdc_req`. It then waits for the destination domain to flip `cdc_ack` back, bringing that acknowledge into its own clock domain with `oclib_synchronizer`. It sits in the sending clock domain, paired with a destination-side receiver that synchronizes `cdc_req`, samples `cdc_data`, and toggles `cdc_ack`.

---
 rtl/oclib_cdc_bus_sender_pkg.sv | 14 +
 rtl/oclib_synchronizer.sv | 22 ++
 rtl/oclib_cdc_bus_sender.sv | 133 +++++++++++++
 tb/tb_oclib_cdc_bus_sender.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/oclib_cdc_bus_sender_pkg.sv
// Sizing helpers for the CDC bus sender.
package oclib_cdc_bus_sender_pkg;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // One register serves both the startup flush and the acknowledge timeout.
  function automatic int unsigned counter_width(input int unsigned sync_cycles,
                                                input int unsigned timeout_cycles);
    return $clog2(max_u(sync_cycles + 1, timeout_cycles) + 1);
  endfunction

endpackage

// File: rtl/oclib_synchronizer.sv
// Plain multi-flop synchronizer; stages are unreset and flushed by the user.
module oclib_synchronizer #(
  parameter int Width      = 1,
  parameter int SyncCycles = 2
) (
  input  logic             clock,
  input  logic [Width-1:0] async_data,
  output logic [Width-1:0] sync_data
);

  logic [Width-1:0] stages [SyncCycles];

  always_ff @(posedge clock) begin
    stages[0] <= async_data;
    for (int i = 1; i < SyncCycles; i++) begin
      stages[i] <= stages[i-1];
    end
  end

  assign sync_data = stages[SyncCycles-1];

endmodule

// File: rtl/oclib_cdc_bus_sender.sv
// Source half of a toggle-handshake bus CDC: holds a word on cdc_data,
// flips cdc_req, and waits for the synchronized cdc_ack toggle.
module oclib_cdc_bus_sender
  import oclib_cdc_bus_sender_pkg::*;
#(
  parameter int Width         = 32,
  parameter int SyncCycles    = 3,
  parameter int TimeoutCycles = 0
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [Width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [Width-1:0] cdc_data,
  output logic             cdc_req,
  input  logic             cdc_ack,
  output logic             busy,
  output logic             timeout_error,
  output logic             ack_error,
  input  logic             clear_error
);

  localparam int CountWidth = counter_width(SyncCycles, TimeoutCycles);
  localparam logic [CountWidth-1:0] StartupLast = CountWidth'(SyncCycles);
  localparam logic [CountWidth-1:0] TimeoutLast =
    CountWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);
  localparam logic [CountWidth-1:0] CountMax = '1;

  generate
    if (SyncCycles < 2 || SyncCycles > 10) begin : g_bad_sync_cycles
      $error("oclib_cdc_bus_sender: SyncCycles must be within 2..10");
    end
    if (Width < 1) begin : g_bad_width
      $error("oclib_cdc_bus_sender: Width must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    Startup = 2'd0,
    Idle    = 2'd1,
    WaitAck = 2'd2
  } state_e;

  state_e                state, state_next;
  logic                  ack_sync, ack_last, ack_last_next;
  logic                  in_ready_next, cdc_req_next;
  logic [Width-1:0]      cdc_data_next;
  logic [CountWidth-1:0] count, count_next;
  logic                  timeout_set, ack_err_set;

  oclib_synchronizer #(
    .Width      (1),
    .SyncCycles (SyncCycles)
  ) ack_synchronizer (
    .clock      (clock),
    .async_data (cdc_ack),
    .sync_data  (ack_sync)
  );

  always_comb begin
    state_next    = state;
    in_ready_next = in_ready;
    cdc_req_next  = cdc_req;
    cdc_data_next = cdc_data;
    ack_last_next = ack_last;
    count_next    = count;
    timeout_set   = 1'b0;
    ack_err_set   = 1'b0;
    unique case (state)
      Startup: begin
        if (count == StartupLast) begin
          ack_last_next = ack_sync;
          in_ready_next = 1'b1;
          count_next    = '0;
          state_next    = Idle;
        end else begin
          count_next = count + CountWidth'(1);
        end
      end
      Idle: begin
        if (ack_sync != ack_last) begin
          ack_last_next = ack_sync;
          ack_err_set   = 1'b1;
        end
        if (in_valid && in_ready) begin
          cdc_data_next = in_data;
          cdc_req_next  = ~cdc_req;
          in_ready_next = 1'b0;
          count_next    = '0;
          state_next    = WaitAck;
        end
      end
      WaitAck: begin
        if (ack_sync != ack_last) begin
          ack_last_next = ack_sync;
          in_ready_next = 1'b1;
          state_next    = Idle;
        end else begin
          if (count != CountMax) count_next = count + CountWidth'(1);
          // A request cannot be retracted, so a timeout only flags.
          if (TimeoutCycles > 0 && count == TimeoutLast) timeout_set = 1'b1;
        end
      end
      default: state_next = Startup;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= Startup;
      in_ready      <= 1'b0;
      busy          <= 1'b1;
      cdc_req       <= 1'b0;
      cdc_data      <= '0;
      ack_last      <= 1'b0;
      count         <= '0;
      timeout_error <= 1'b0;
      ack_error     <= 1'b0;
    end else begin
      state         <= state_next;
      in_ready      <= in_ready_next;
      busy          <= (state_next != Idle);
      cdc_req       <= cdc_req_next;
      cdc_data      <= cdc_data_next;
      ack_last      <= ack_last_next;
      count         <= count_next;
      timeout_error <= timeout_set | (timeout_error & ~clear_error);
      ack_error     <= ack_err_set | (ack_error & ~clear_error);
    end
  end

endmodule

// File: tb/tb_oclib_cdc_bus_sender.sv
// Self-checking bench for oclib_cdc_bus_sender with a behavioural destination model.
`timescale 1ns/1ps
module tb_oclib_cdc_bus_sender;

  localparam int W  = 32;
  localparam int SC = 3;
  localparam int TO = 16;

  logic         clock, resetn;
  logic [W-1:0] in_data;
  logic         in_valid, in_ready;
  logic [W-1:0] cdc_data;
  logic         cdc_req, cdc_ack;
  logic         busy, timeout_error, ack_error, clear_error;
  logic         dest_ack, manual_ack;

  assign cdc_ack = dest_ack ^ manual_ack;

  oclib_cdc_bus_sender #(.Width(W), .SyncCycles(SC), .TimeoutCycles(TO)) dut (
    .clock(clock), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .cdc_data(cdc_data), .cdc_req(cdc_req), .cdc_ack(cdc_ack),
    .busy(busy), .timeout_error(timeout_error), .ack_error(ack_error),
    .clear_error(clear_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int passed = 0;

  // Destination model: sees a req toggle, captures the word, toggles ack after a delay.
  int           cyc;
  logic         dest_en;
  int           dly_min, dly_max;
  logic         dest_req_last;
  int           dest_cnt;
  int           last_ack_cap;
  int           req_toggles;
  int           dest_hold_bad;
  logic [W-1:0] dest_word;
  logic [W-1:0] rx_q[$];

  initial begin
    cyc = 0; dest_ack = 1'b0; dest_req_last = 1'b0; dest_cnt = -1;
    last_ack_cap = 0; req_toggles = 0; dest_hold_bad = 0; dest_word = '0;
    forever begin
      @(posedge clock);
      cyc++;
      #2;
      if (!resetn) begin
        dest_ack = 1'b0; dest_req_last = 1'b0; dest_cnt = -1;
      end else if (cdc_req !== dest_req_last) begin
        dest_req_last = cdc_req;
        req_toggles++;
        if (dest_en) begin
          dest_word = cdc_data;
          rx_q.push_back(cdc_data);
          dest_cnt = $urandom_range(dly_max, dly_min);
        end
      end else if (dest_cnt > 0) begin
        if (cdc_data !== dest_word) dest_hold_bad++;
        dest_cnt--;
        if (dest_cnt == 0) begin
          dest_ack = ~dest_ack;
          last_ack_cap = cyc + 1;
          dest_cnt = -1;
        end
      end
    end
  end

  task automatic send_word(input logic [W-1:0] w, output int acc_edge);
    acc_edge = -1;
    in_data  = w;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (in_ready) begin
        @(negedge clock);
        acc_edge = cyc;
        break;
      end
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic test_reset();
    int bad = 0;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; clear_error = 1'b0;
    manual_ack = 1'b0; dest_en = 1'b1; dly_min = 2; dly_max = 2;
    repeat (3) @(negedge clock);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passed++;
    checks++; if (busy !== 1'b1) $display("FAIL reset_busy got %b want 1", busy); else passed++;
    checks++; if (cdc_req !== 1'b0 || cdc_data !== '0)
      $display("FAIL reset_cdc got req=%b data=%h want 0/0", cdc_req, cdc_data); else passed++;
    checks++; if ({timeout_error, ack_error} !== 2'b00)
      $display("FAIL reset_errors got %b want 00", {timeout_error, ack_error}); else passed++;
    resetn = 1'b1;
    for (int k = 1; k <= SC + 1; k++) begin
      @(negedge clock);
      if (in_ready !== (k == SC + 1)) bad++;
      if (cdc_req !== 1'b0 || cdc_data !== '0) bad++;
    end
    checks++; if (bad != 0) $display("FAIL startup_sequence got %0d bad edges want 0", bad); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL startup_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_single_word();
    int acc, hold_bad = 0, t0;
    dly_min = 5; dly_max = 5; rx_q.delete(); t0 = req_toggles;
    send_word(32'hDEADBEEF, acc);
    for (int i = 0; i < 40 && !in_ready; i++) begin
      if (cdc_data !== 32'hDEADBEEF) hold_bad++;
      @(negedge clock);
    end
    checks++; if (acc < 0 || in_ready !== 1'b1)
      $display("FAIL single_ready got acc=%0d ready=%b want accept and ready", acc, in_ready); else passed++;
    checks++; if (cyc != last_ack_cap + SC)
      $display("FAIL single_latency got edge %0d want %0d", cyc, last_ack_cap + SC); else passed++;
    checks++; if (req_toggles - t0 != 1)
      $display("FAIL single_toggles got %0d want 1", req_toggles - t0); else passed++;
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 32'hDEADBEEF)
      $display("FAIL single_rx got size %0d want 1 word deadbeef", rx_q.size()); else passed++;
    checks++; if (hold_bad != 0 || cdc_data !== 32'hDEADBEEF)
      $display("FAIL single_hold got %0d unstable cycles want 0", hold_bad); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q[$];
    int acc = 0, spacing_bad = 0, mism = 0, t0;
    dly_min = 1; dly_max = 4; rx_q.delete(); t0 = req_toggles; dest_hold_bad = 0;
    in_valid = 1'b1; in_data = $urandom;
    for (int c = 0; c < 3000 && acc < 100; c++) begin
      if (in_ready) begin
        exp_q.push_back(in_data);
        if (acc > 0 && cyc + 1 != last_ack_cap + SC + 1) spacing_bad++;
        acc++;
      end
      @(negedge clock);
      in_data = $urandom;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clock);
    checks++; if (acc != 100) $display("FAIL b2b_accepts got %0d want 100", acc); else passed++;
    checks++; if (req_toggles - t0 != 100)
      $display("FAIL b2b_toggles got %0d want 100", req_toggles - t0); else passed++;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) mism++;
    checks++; if (mism != 0 || rx_q.size() != exp_q.size())
      $display("FAIL b2b_order got %0d mismatched of %0d want 0", mism, rx_q.size()); else passed++;
    checks++; if (spacing_bad != 0)
      $display("FAIL b2b_spacing got %0d bad accepts want 0", spacing_bad); else passed++;
    checks++; if (dest_hold_bad != 0)
      $display("FAIL b2b_hold got %0d unstable cycles want 0", dest_hold_bad); else passed++;
    checks++; if (busy !== 1'b0 || ack_error !== 1'b0 || timeout_error !== 1'b0)
      $display("FAIL b2b_idle got busy=%b errs=%b%b want 0/00", busy, timeout_error, ack_error); else passed++;
  endtask

  task automatic test_timeout();
    int acc, early = 0, busy_bad = 0;
    dest_en = 1'b0;
    send_word($urandom, acc);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clock);
      if (k < TO && timeout_error !== 1'b0) early++;
      if (busy !== 1'b1) busy_bad++;
    end
    checks++; if (acc < 0 || cyc != acc + TO)
      $display("FAIL timeout_edge got edge %0d want %0d", cyc, acc + TO); else passed++;
    checks++; if (early != 0) $display("FAIL timeout_early got %0d want 0", early); else passed++;
    checks++; if (timeout_error !== 1'b1) $display("FAIL timeout_set got %b want 1", timeout_error); else passed++;
    checks++; if (busy_bad != 0 || in_ready !== 1'b0)
      $display("FAIL timeout_busy got %0d bad ready=%b want 0/0", busy_bad, in_ready); else passed++;
    manual_ack = ~manual_ack;
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clock);
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL late_ack_idle got ready=%b busy=%b want 1/0", in_ready, busy); else passed++;
    checks++; if (timeout_error !== 1'b1)
      $display("FAIL timeout_sticky got %b want 1", timeout_error); else passed++;
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
    checks++; if (timeout_error !== 1'b0)
      $display("FAIL timeout_clear got %b want 0", timeout_error); else passed++;
    dest_en = 1'b1;
  endtask

  task automatic test_ack_error();
    manual_ack = ~manual_ack;
    repeat (SC + 1) @(negedge clock);
    checks++; if (ack_error !== 1'b1) $display("FAIL ack_err_set got %b want 1", ack_error); else passed++;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL ack_err_ready got ready=%b busy=%b want 1/0", in_ready, busy); else passed++;
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
    checks++; if (ack_error !== 1'b0) $display("FAIL ack_err_clear got %b want 0", ack_error); else passed++;
    manual_ack = ~manual_ack;
    repeat (SC) @(negedge clock);
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
    checks++; if (ack_error !== 1'b1)
      $display("FAIL ack_err_set_wins got %b want 1", ack_error); else passed++;
    clear_error = 1'b1;
    @(negedge clock);
    clear_error = 1'b0;
  endtask

  task automatic test_reset_mid();
    int acc, bad = 0;
    logic [W-1:0] w;
    dly_min = 30; dly_max = 30;
    send_word($urandom, acc);
    repeat (20) @(negedge clock);
    checks++; if (busy !== 1'b1 || timeout_error !== 1'b1)
      $display("FAIL mid_pre got busy=%b timeout=%b want 1/1", busy, timeout_error); else passed++;
    #2;
    resetn = 1'b0; manual_ack = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL mid_reset_hs got ready=%b busy=%b want 0/1", in_ready, busy); else passed++;
    checks++; if (cdc_req !== 1'b0 || cdc_data !== '0)
      $display("FAIL mid_reset_cdc got req=%b data=%h want 0/0", cdc_req, cdc_data); else passed++;
    checks++; if ({timeout_error, ack_error} !== 2'b00)
      $display("FAIL mid_reset_errs got %b want 00", {timeout_error, ack_error}); else passed++;
    @(negedge clock); @(negedge clock);
    resetn = 1'b1;
    for (int k = 1; k <= SC + 1; k++) begin
      @(negedge clock);
      if (in_ready !== (k == SC + 1)) bad++;
    end
    checks++; if (bad != 0) $display("FAIL mid_startup got %0d bad edges want 0", bad); else passed++;
    dly_min = 2; dly_max = 2; rx_q.delete(); w = $urandom;
    send_word(w, acc);
    for (int i = 0; i < 30 && !in_ready; i++) @(negedge clock);
    checks++; if (rx_q.size() != 1 || rx_q[0] !== w || cdc_req !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL mid_resend got size=%0d req=%b ready=%b want 1/1/1", rx_q.size(), cdc_req, in_ready);
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_timeout();
    test_ack_error();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
